// File: rtl/rst_pkg.sv
// Shared reset-sequencing definitions for every clock domain.
//   rst_state_e       : FSM state encoding of the reset sequencer
//   RST_HOLD_DEFAULT  : default cycles all outputs stay asserted
//   RST_STEP_DEFAULT  : default cycles between staged releases
//   rst_max()         : integer max, used to size counters
package rst_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } rst_state_e;

  localparam int RST_HOLD_DEFAULT = 16;
  localparam int RST_STEP_DEFAULT = 4;

  function automatic int rst_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_seq_if.sv
// Soft-reset handshake and staged reset outputs of rst_sync_seq.
//   sw_rst_req : level request for a soft reset (driven by master)
//   sw_rst_ack : 1-cycle pulse, request accepted (driven by slave)
//   rst_out_n  : staged active-low resets, bit 0 released first (slave)
//   rst_done   : all outputs released, sequencer idle (slave)
interface rst_sync_seq_if #(
  parameter int NUM_OUT = 3
);

  logic               sw_rst_req;
  logic               sw_rst_ack;
  logic [NUM_OUT-1:0] rst_out_n;
  logic               rst_done;

  modport master (
    output sw_rst_req,
    input  sw_rst_ack,
    input  rst_out_n,
    input  rst_done
  );

  modport slave (
    input  sw_rst_req,
    output sw_rst_ack,
    output rst_out_n,
    output rst_done
  );

endinterface

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously with rstn, releases
// SYNC_STAGES clk edges after rstn deasserts.
//   clk        : destination clock
//   rstn       : raw async active-low reset
//   rst_sync_n : synchronized active-low reset
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  output logic rst_sync_n
);

  // Metastability chain; keep these flops adjacent and untimed on D.
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sync_seq.sv
// Staged reset sequencer for one clock domain. Asserts all resets
// asynchronously on rstn, releases them one by one after a hold period,
// and supports a software-requested soft reset once idle.
//   clk  : domain clock
//   rstn : raw async active-low reset (pad/POR)
//   bus  : soft-reset handshake and staged reset outputs (slave side)
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   ST_ASSERT  | all outputs asserted, counting HOLD_CYCLES of sync release
//   ST_RELEASE | releasing one more output every STEP_CYCLES
//   ST_DONE    | all outputs released; soft-reset requests accepted here
module rst_sync_seq
  import rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = RST_HOLD_DEFAULT,
  parameter int STEP_CYCLES = RST_STEP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn,
  rst_sync_seq_if.slave        bus
);

  localparam int CNT_W = $clog2(rst_max(HOLD_CYCLES, STEP_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  logic               rst_sync_n;
  rst_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               done_q, done_d;
  logic               ack_q, ack_d;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk        (clk),
    .rstn       (rstn),
    .rst_sync_n (rst_sync_n)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = done_q;
    ack_d   = 1'b0;
    unique case (state_q)
      ST_ASSERT: begin
        // After a soft reset rst_sync_n is already high, so the hold
        // period starts on the very next edge.
        if (rst_sync_n) begin
          if (cnt_q == HOLD_LAST) begin
            out_d[0] = 1'b1;
            cnt_d    = '0;
            if (NUM_OUT == 1) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RELEASE: begin
        if (cnt_q == STEP_LAST) begin
          // Released bits form a thermometer from bit 0 upward, so
          // shifting in the next bit releases exactly one more output.
          out_d = out_q | (out_q << 1);
          cnt_d = '0;
          if (&out_d) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.sw_rst_req) begin
          out_d   = '0;
          done_d  = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_ASSERT;
        end
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase
  end

  assign bus.rst_out_n  = out_q;
  assign bus.rst_done   = done_q;
  assign bus.sw_rst_ack = ack_q;

endmodule
